gf_digit_serial_mul: RTL and testbench

- Parametrised successor to the team's serial GF(2^W) multiplier.
- Multiplies LANES independent element pairs in GF(2^W) under a reduction polynomial P that is selected at run time.
- Processes DIGIT bits of the multiplier operand per cycle, so one operation takes W/DIGIT cycles.
- Uses a valid/ready handshake on both sides, with output backpressure and back-to-back issue.
- Sits between the state register and the CLM datapath, replacing the drdy_i/drdy_o-style multiplier.

---
 rtl/gf_digit_serial_mul_pkg.sv | 21 ++
 rtl/gf_digit_serial_mul_step.sv | 33 +++
 rtl/gf_digit_serial_mul.sv | 147 ++++++++++++++
 tb/tb_gf_digit_serial_mul.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_digit_serial_mul_pkg.sv
// Shared types and constants for the digit-serial GF(2^W) multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf_digit_serial_mul_pkg;

    // Default build point: field degree, digit width and lane count.
    localparam int GF_W       = 8;
    localparam int GF_DIGIT   = 2;
    localparam int GF_LANES   = 16;
    localparam int GF_NDIGITS = GF_W / GF_DIGIT;

    typedef logic [GF_W-1:0]           gf_elem_t;
    typedef gf_elem_t [GF_LANES-1:0]   lane_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/gf_digit_serial_mul_step.sv
// One lane, one cycle: DIGIT MSB-first Horner steps acc = xt(acc) ^ (bit ? a : 0).
// Latency: combinational.
// Backpressure: none.
// Ports: acc/a/P are W-bit field elements, digit is the DIGIT-bit multiplier slice
// (MSB consumed first), acc_next is the accumulator after all DIGIT steps.
module gf_digit_step #(
    parameter int W     = 8,
    parameter int DIGIT = 2
) (
    input  logic [W-1:0]     acc,
    input  logic [W-1:0]     a,
    input  logic [DIGIT-1:0] digit,
    input  logic [W-1:0]     P,
    output logic [W-1:0]     acc_next
);

    always_comb begin : p_steps
        logic [W-1:0]     v;
        logic [DIGIT-1:0] d;
        v = acc;
        d = digit;
        for (int j = 0; j < DIGIT; j++) begin
            // Multiply by x, folding x^W back in through the low coefficients of P.
            v = (v << 1) ^ (v[W-1] ? P : '0);
            if (d[DIGIT-1]) begin
                v = v ^ a;
            end
            d = d << 1;
        end
        acc_next = v;
    end

endmodule

// File: rtl/gf_digit_serial_mul.sv
// LANES-wide GF(2^W) multiplier, DIGIT multiplier bits per cycle, run-time polynomial P.
// Latency: operands accepted on edge k, out_valid after edge k+W/DIGIT.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there.
// Ports: clk/rst (async active-low); in_valid/in_ready with p1, p2 (LANES*W) and P (W);
// out_valid/out_ready with out (LANES*W); busy flags the BUSY state.
module gf_digit_serial_mul
    import gf_digit_serial_mul_pkg::*;
#(
    parameter int W     = 8,
    parameter int DIGIT = 2,
    parameter int LANES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] p1,
    input  logic [LANES*W-1:0] p2,
    input  logic [W-1:0]       P,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out,
    output logic               busy
);

    localparam int            NDIG     = W / DIGIT;
    localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    if ((W % DIGIT) != 0) begin : g_bad_digit
        $error("gf_digit_serial_mul: DIGIT must divide W");
    end

    mul_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LANES*W-1:0] a_q, a_d;
    logic [LANES*W-1:0] b_q, b_d;
    logic [W-1:0]       p_q, p_d;
    logic [LANES*W-1:0] acc_q, acc_d;
    logic [LANES*W-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic [LANES*W-1:0] acc_step;
    logic [LANES*W-1:0] b_shift;
    logic               ready_c;
    logic               load;

    // b_q is shifted left one digit per BUSY cycle, so the digit to consume
    // (b[W-1-cnt*DIGIT -: DIGIT] of the latched operand) is always the top
    // DIGIT bits of each lane; this keeps every select constant.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gf_digit_step #(
            .W     (W),
            .DIGIT (DIGIT)
        ) u_step (
            .acc      (acc_q[l*W +: W]),
            .a        (a_q[l*W +: W]),
            .digit    (b_q[l*W + W - DIGIT +: DIGIT]),
            .P        (p_q),
            .acc_next (acc_step[l*W +: W])
        );

        assign b_shift[l*W +: W] = b_q[l*W +: W] << DIGIT;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        p_d         = p_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ready_c     = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                load    = in_valid;
            end
            BUSY: begin
                acc_d = acc_step;
                b_d   = b_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d       = acc_step;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // Retiring and accepting share one edge, so back-to-back
                // operations lose only this single DONE cycle.
                ready_c = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    load        = in_valid;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            a_d     = p1;
            b_d     = p2;
            p_d     = P;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Registers clear to IDLE on reset, which alone would raise in_ready;
    // gating with rst keeps the source stalled until reset is released.
    assign in_ready  = rst & ready_c;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_gf_digit_serial_mul.sv
module tb_gf_digit_serial_mul;

    localparam int W     = 8;
    localparam int DIGIT = 2;
    localparam int LANES = 16;
    localparam int NDIG  = W / DIGIT;
    localparam int TOT   = LANES * W;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [TOT-1:0] p1, p2;
    logic [7:0]     P;
    logic           out_valid;
    logic           out_ready;
    logic [TOT-1:0] out;
    logic           busy;

    // Single-lane builds with DIGIT=1 and DIGIT=8.
    logic       s_v1, s_v8, s_rdy;
    logic [7:0] s_a, s_b, s_p;
    logic       r1_ir, r1_ov, r1_busy, r8_ir, r8_ov, r8_busy;
    logic [7:0] r1_out, r8_out;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int rdy_mode = 0;   // 0: out_ready high, 1: low, 2: random

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_digit_serial_mul #(.W(W), .DIGIT(DIGIT), .LANES(LANES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p1(p1), .p2(p2), .P(P), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    gf_digit_serial_mul #(.W(8), .DIGIT(1), .LANES(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .in_valid(s_v1), .in_ready(r1_ir),
        .p1(s_a), .p2(s_b), .P(s_p), .out_valid(r1_ov), .out_ready(s_rdy),
        .out(r1_out), .busy(r1_busy)
    );

    gf_digit_serial_mul #(.W(8), .DIGIT(8), .LANES(1)) u_dut_d8 (
        .clk(clk), .rst(rst), .in_valid(s_v8), .in_ready(r8_ir),
        .p1(s_a), .p2(s_b), .P(s_p), .out_valid(r8_ov), .out_ready(s_rdy),
        .out(r8_out), .busy(r8_busy)
    );

    task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Textbook shift-and-add GF(2^8) product, LSB of b first.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ p) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [TOT-1:0] model_vec(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic [7:0] p);
        logic [TOT-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*W +: W] = gf_mul(a[l*W +: W], b[l*W +: W], p);
        return r;
    endfunction

    function automatic logic [TOT-1:0] rand_vec();
        logic [TOT-1:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Scoreboard: expected results in accept order, compared every cycle.
    logic [TOT-1:0] exp_q[$];
    int             acc_q[$];
    logic [TOT-1:0] last_out;
    bit             lat_done;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            acc_q.delete();
            lat_done = 1'b0;
            last_out = '0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out", out, 0);
            chk("rst_in_ready", in_ready, 0);
        end else begin
            chk("in_ready", in_ready, out_valid ? out_ready : (exp_q.size() == 0));
            chk("busy", busy, !out_valid && exp_q.size() != 0);
            if (!out_valid) begin
                chk("out_hold", out, last_out);
                if (exp_q.size() != 0 && cyc - acc_q[0] > NDIG) chk("out_valid_late", out_valid, 1);
            end else if (exp_q.size() == 0) begin
                chk("out_valid_spurious", out_valid, 0);
            end else begin
                chk("out", out, exp_q[0]);
                if (!lat_done) begin
                    chk("latency", cyc - acc_q[0], NDIG);
                    lat_done = 1'b1;
                end
                last_out = exp_q[0];
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    lat_done = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_vec(p1, p2, P));
                acc_q.push_back(cyc + 1);
            end
        end
    end

    // Sole driver of out_ready; changes 2 time units after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic issue(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic [7:0] p, output int acc);
        acc = -1;
        p1 = a;
        p2 = b;
        P  = p;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (acc < 0) chk("issue_timeout", in_ready, 1);
    endtask

    task automatic wait_valid(input int acc, output logic [TOT-1:0] v, output int lat);
        lat = -1;
        v   = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid) begin
                v   = out;
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) chk("wait_valid_timeout", out_valid, 1);
    endtask

    task automatic small_op(input bit sel8, input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                            output logic [7:0] v, output int lat);
        int    acc;
        string tag;
        tag = sel8 ? "d8" : "d1";
        s_a = a;
        s_b = b;
        s_p = p;
        @(posedge clk);
        #1;
        if (sel8) s_v8 = 1'b1;
        else      s_v1 = 1'b1;
        @(posedge clk);
        #1;
        acc  = cyc;
        s_v1 = 1'b0;
        s_v8 = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, sel8 ? r8_busy : r1_busy, 1);
        chk({tag, "_in_ready"}, sel8 ? r8_ir : r1_ir, 0);
        lat = -1;
        v   = '0;
        for (int i = 0; i < 20; i++) begin
            if (sel8 ? r8_ov : r1_ov) begin
                v   = sel8 ? r8_out : r1_out;
                lat = cyc - acc;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk({tag, "_timeout"}, sel8 ? r8_ov : r1_ov, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TOT-1:0] a, b, v;
        logic [7:0]     sa, sb, sp, sv;
        int             acc, acc2, lat;

        rst = 1'b0; in_valid = 1'b0; p1 = '0; p2 = '0; P = 8'h1B;
        s_v1 = 1'b0; s_v8 = 1'b0; s_rdy = 1'b1; s_a = '0; s_b = '0; s_p = 8'h1B;

        // Model pinned to known AES-field products.
        chk("model_57x83", gf_mul(8'h57, 8'h83, 8'h1B), 8'hC1);
        chk("model_02x80", gf_mul(8'h02, 8'h80, 8'h1B), 8'h1B);
        chk("model_57x13", gf_mul(8'h57, 8'h13, 8'h1B), 8'hFE);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("post_reset_in_ready", in_ready, 1);

        // Single lane 0x57*0x83.
        a = '0; b = '0;
        a[7:0] = 8'h57; b[7:0] = 8'h83;
        issue(a, b, 8'h1B, acc);
        wait_valid(acc, v, lat);
        chk("t1_lane0", v[7:0], 8'hC1);
        chk("t1_other_lanes", v[TOT-1:8], 0);
        chk("t1_latency", lat, 4);
        @(posedge clk); #1;

        // All lanes: identity, two special products, p1=0 on lane 0.
        a = '0; b = '0;
        for (int l = 0; l < LANES; l++) begin
            a[l*W +: W] = 8'(l);
            b[l*W +: W] = 8'h01;
        end
        a[3*W +: W] = 8'h02; b[3*W +: W] = 8'h80;
        a[5*W +: W] = 8'h57; b[5*W +: W] = 8'h13;
        issue(a, b, 8'h1B, acc);
        wait_valid(acc, v, lat);
        for (int l = 0; l < LANES; l++)
            chk($sformatf("t2_lane%0d", l), v[l*W +: W], (l == 3) ? 8'h1B : (l == 5) ? 8'hFE : 8'(l));
        @(posedge clk); #1;

        // Backpressure hold with P changed during the hold.
        rdy_mode = 1;
        a = {LANES{8'h57}}; b = {LANES{8'h83}};
        issue(a, b, 8'h1B, acc);
        wait_valid(acc, v, lat);
        chk("t3_value", v, {LANES{8'hC1}});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) P = 8'h11;
            @(negedge clk);
            chk("t3_out_stable", out, v);
            chk("t3_out_valid", out_valid, 1);
            chk("t3_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("t3_retired", out_valid, 0);
        chk("t3_out_kept", out, v);

        // Back-to-back: second accept on the retire edge of the first.
        issue({LANES{8'h57}}, {LANES{8'h83}}, 8'h1B, acc);
        issue({LANES{8'h02}}, {LANES{8'h80}}, 8'h1B, acc2);
        chk("t4_gap", acc2 - acc, NDIG + 1);
        wait_valid(acc2, v, lat);
        chk("t4_second", v, {LANES{8'h1B}});
        chk("t4_latency", lat, 4);
        @(posedge clk); #1;

        // Reset during BUSY cycle 2.
        issue(rand_vec(), rand_vec(), 8'h1D, acc);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out", out, 0);
        chk("t5_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("t5_in_ready_release", in_ready, 1);
        a = '0; b = '0;
        a[7:0] = 8'h57; b[7:0] = 8'h83;
        issue(a, b, 8'h1B, acc);
        wait_valid(acc, v, lat);
        chk("t5_after_reset", v[7:0], 8'hC1);
        @(posedge clk); #1;

        // Random sweep with random backpressure and operand churn while busy.
        rdy_mode = 2;
        for (int n = 0; n < 1000; n++) begin
            issue(rand_vec(), rand_vec(), ($urandom_range(0, 1) != 0) ? 8'h1B : 8'h1D, acc);
            p1 = rand_vec();
            p2 = rand_vec();
            P  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rdy_mode = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", exp_q.size(), 0);

        // DIGIT=1 and DIGIT=8 builds.
        for (int n = 0; n < 21; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (n == 0) begin
                    sa = 8'h57; sb = 8'h83; sp = 8'h1B;
                end else begin
                    sa = 8'($urandom); sb = 8'($urandom);
                    sp = ($urandom_range(0, 1) != 0) ? 8'h1B : 8'h1D;
                end
                small_op(s == 1, sa, sb, sp, sv, lat);
                chk((s == 1) ? "d8_value" : "d1_value", sv, gf_mul(sa, sb, sp));
                chk((s == 1) ? "d8_latency" : "d1_latency", lat, (s == 1) ? 1 : 8);
                if (n == 0) chk((s == 1) ? "d8_57x83" : "d1_57x83", sv, 8'hC1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
